// File: rtl/hpi_bus_arbiter.sv
// Two-port arbiter onto the CY7C67200 HPI bus: chip reset sequencing, CS/RD/WR timing, data direction.
// Build option: define HPI_LOCK_EN to honour a_lock/b_lock (bus held by the last locked winner).
module hpi_bus_arbiter #(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 4,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 2,
    parameter int RST_CYC     = 16
) (
    input  logic        Clk,
    input  logic        Reset,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [1:0]  a_addr,
    input  logic [15:0] a_wdata,
    input  logic        a_lock,
    output logic        a_done,
    output logic [15:0] a_rdata,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [1:0]  b_addr,
    input  logic [15:0] b_wdata,
    input  logic        b_lock,
    output logic        b_done,
    output logic [15:0] b_rdata,

    output logic [1:0]  hpi_addr,
    output logic        hpi_cs_n,
    output logic        hpi_rd_n,
    output logic        hpi_wr_n,
    output logic        hpi_rst_n,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    input  logic [15:0] hpi_data_in,
    output logic        busy,

    output logic [2:0]  dbg_state_o
);

    // Handshake: a requester raises req with its fields stable and holds them until
    // its done pulse; it must drop req the cycle after done. A req seen high in IDLE
    // is always treated as a new request.

    localparam int MAX_SS = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_HR = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
    localparam int MAX_PH = (MAX_SS > MAX_HR) ? MAX_SS : MAX_HR;
    localparam int MAX_C  = (MAX_PH > RST_CYC) ? MAX_PH : RST_CYC;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] SETUP_LD   = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LD  = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD    = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] RECOVER_LD = CW'((RECOVER_CYC > 0) ? RECOVER_CYC - 1 : 0);
    localparam logic [CW-1:0] RST_LD     = CW'(RST_CYC);

    typedef enum logic [2:0] {
        ST_CHIPRST = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SETUP   = 3'd2,
        ST_STROBE  = 3'd3,
        ST_HOLD    = 3'd4,
        ST_RECOVER = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_cyc;

    logic          grant_a, grant_b, contend;
    logic          win_lock;

    logic          win_q;       // 0 = port A, 1 = port B
    logic          we_q;
    logic          lock_q;
    logic [1:0]    addr_q;
    logic [15:0]   wdata_q;
    logic [15:0]   a_rdata_q, b_rdata_q;
    logic          rr_q;        // 0 = A wins next contention, 1 = B
    logic          own_vld_q;
    logic          own_b_q;

    assign last_cyc = (cnt_q == '0);

    // Arbitration is only meaningful in IDLE; a lock owner excludes the other side.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        contend = 1'b0;
        if (state_q == ST_IDLE) begin
            if (own_vld_q) begin
                grant_a = a_req && !own_b_q;
                grant_b = b_req &&  own_b_q;
            end else if (a_req && b_req) begin
                contend = 1'b1;
                grant_a = !rr_q;
                grant_b =  rr_q;
            end else begin
                grant_a = a_req;
                grant_b = b_req;
            end
        end
    end

`ifdef HPI_LOCK_EN
    assign win_lock = grant_b ? b_lock : a_lock;
`else
    logic unused_lock;
    assign unused_lock = a_lock ^ b_lock;
    assign win_lock    = 1'b0;
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_CHIPRST;
            cnt_q   <= RST_LD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter reloads on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = last_cyc ? cnt_q : cnt_q - 1'b1;
        case (state_q)
            ST_CHIPRST: begin
                if (last_cyc) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (grant_a || grant_b) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (last_cyc) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LD;
                end
            end
            ST_STROBE: begin
                if (last_cyc) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (last_cyc) begin
                    if (RECOVER_CYC == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RECOVER;
                        cnt_d   = RECOVER_LD;
                    end
                end
            end
            ST_RECOVER: begin
                if (last_cyc) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CHIPRST;
                cnt_d   = RST_LD;
            end
        endcase
    end

    // Access context, read capture, round-robin pointer and lock owner.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            lock_q    <= 1'b0;
            addr_q    <= 2'd0;
            wdata_q   <= 16'd0;
            a_rdata_q <= 16'd0;
            b_rdata_q <= 16'd0;
            rr_q      <= 1'b0;
            own_vld_q <= 1'b0;
            own_b_q   <= 1'b0;
        end else begin
            if (grant_a || grant_b) begin
                win_q   <= grant_b;
                we_q    <= grant_b ? b_we    : a_we;
                addr_q  <= grant_b ? b_addr  : a_addr;
                wdata_q <= grant_b ? b_wdata : a_wdata;
                lock_q  <= win_lock;
                if (contend) rr_q <= grant_a;
            end
            if (state_q == ST_STROBE && last_cyc && !we_q) begin
                if (win_q) b_rdata_q <= hpi_data_in;
                else       a_rdata_q <= hpi_data_in;
            end
            if (state_q == ST_HOLD && last_cyc) begin
                own_vld_q <= lock_q;
                own_b_q   <= win_q;
            end
        end
    end

    // Output decode; chip select spans SETUP through HOLD.
    always_comb begin
        busy         = (state_q != ST_IDLE);
        hpi_cs_n     = !(state_q == ST_SETUP || state_q == ST_STROBE || state_q == ST_HOLD);
        hpi_rd_n     = !(state_q == ST_STROBE && !we_q);
        hpi_wr_n     = !(state_q == ST_STROBE &&  we_q);
        hpi_data_oe  = !hpi_cs_n && we_q;
        hpi_rst_n    = !(state_q == ST_CHIPRST && !last_cyc);
        hpi_addr     = addr_q;
        hpi_data_out = wdata_q;
        a_done       = (state_q == ST_HOLD) && last_cyc && !win_q;
        b_done       = (state_q == ST_HOLD) && last_cyc &&  win_q;
        a_rdata      = a_rdata_q;
        b_rdata      = b_rdata_q;
        dbg_state_o  = state_q;
    end

endmodule

// File: tb/tb_hpi_bus_arbiter.sv
// Directed bench for hpi_bus_arbiter: chip reset, write/read timing, round-robin, lock, mid-access reset.
module tb_hpi_bus_arbiter;

    logic        Clk;
    logic        Reset;
    logic        a_req, a_we, a_lock, a_done;
    logic [1:0]  a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic        b_req, b_we, b_lock, b_done;
    logic [1:0]  b_addr;
    logic [15:0] b_wdata, b_rdata;
    logic [1:0]  hpi_addr;
    logic        hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_rst_n, hpi_data_oe, busy;
    logic [15:0] hpi_data_out, hpi_data_in;
    logic [2:0]  dbg_state_o;

    logic [15:0] chip_q;
    logic [15:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Chip model: read data appears on the pad only while RD_n is low.
    assign hpi_data_in = !hpi_rd_n ? chip_q : 16'h0000;

    hpi_bus_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
        .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
        .b_done(b_done), .b_rdata(b_rdata),
        .hpi_addr(hpi_addr), .hpi_cs_n(hpi_cs_n), .hpi_rd_n(hpi_rd_n), .hpi_wr_n(hpi_wr_n),
        .hpi_rst_n(hpi_rst_n), .hpi_data_out(hpi_data_out), .hpi_data_oe(hpi_data_oe),
        .hpi_data_in(hpi_data_in), .busy(busy), .dbg_state_o(dbg_state_o)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Metrics of one single-port access
    int          m_first_cs, m_first_strobe, m_wr_low, m_rd_low, m_pin_bad;
    int          m_done_idx, m_other_done, m_recover;
    logic        m_done_cs_n;
    logic [15:0] m_rdata;

    task automatic run_access(input logic sb, input logic we, input logic [1:0] ad,
                              input logic [15:0] wd);
        int  c;
        logic done_seen;
        if (sb) begin
            b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = wd; b_lock = 1'b0;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd; a_lock = 1'b0;
        end
        m_first_cs = 0; m_first_strobe = 0; m_wr_low = 0; m_rd_low = 0; m_pin_bad = 0;
        m_done_idx = -1; m_other_done = 0; m_recover = 0; m_done_cs_n = 1'b1; m_rdata = 16'h0;
        c = 0;
        done_seen = 1'b0;
        while (!done_seen && c < 40) begin
            tick();
            c++;
            if (!hpi_cs_n && m_first_cs == 0) m_first_cs = c;
            if ((!hpi_wr_n || !hpi_rd_n) && m_first_strobe == 0) m_first_strobe = c;
            if (!hpi_wr_n) m_wr_low++;
            if (!hpi_rd_n) m_rd_low++;
            if (!hpi_wr_n && !hpi_rd_n) m_pin_bad++;
            if (hpi_cs_n && (!hpi_wr_n || !hpi_rd_n)) m_pin_bad++;
            if (!hpi_cs_n && (hpi_data_oe !== we || hpi_addr !== ad)) m_pin_bad++;
            if (!hpi_cs_n && we && hpi_data_out !== wd) m_pin_bad++;
            if (sb ? a_done : b_done) m_other_done++;
            if (sb ? b_done : a_done) begin
                done_seen   = 1'b1;
                m_done_idx  = c - m_first_cs + 1;
                m_rdata     = sb ? b_rdata : a_rdata;
                m_done_cs_n = hpi_cs_n;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (hpi_cs_n && busy) m_recover++;
            if (!hpi_cs_n) m_pin_bad++;
        end
    endtask

    task automatic do_reset();
        int c;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        c = 0;
        while (busy && c < 100) begin
            tick();
            c++;
        end
        check_eq("reset_to_idle", busy, 1'b0);
    endtask

    initial begin : main
        int   low_cnt, bad, c, n_done, a_cnt, b_cnt, both;
        logic a_re, b_re, found;
        logic [15:0] e;

        Reset = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_lock = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_lock = 0;
        chip_q = 16'h0000;

        // Reset state and chip-reset sequence
        repeat (3) tick();
        check_eq("rst_cs_n", hpi_cs_n, 1'b1);
        check_eq("rst_rd_n", hpi_rd_n, 1'b1);
        check_eq("rst_wr_n", hpi_wr_n, 1'b1);
        check_eq("rst_hpi_rst_n", hpi_rst_n, 1'b0);
        check_eq("rst_addr", hpi_addr, 2'd0);
        check_eq("rst_data_out", hpi_data_out, 16'h0);
        check_eq("rst_data_oe", hpi_data_oe, 1'b0);
        check_eq("rst_dones", {a_done, b_done}, 2'b00);
        check_eq("rst_rdata", {a_rdata, b_rdata}, 32'h0);
        check_eq("rst_busy", busy, 1'b1);
        check_eq("rst_state", dbg_state_o, 3'd0);
        Reset = 1'b0;
        low_cnt = 1;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (!hpi_cs_n || !hpi_rd_n || !hpi_wr_n) bad++;
            if (hpi_rst_n) break;
            low_cnt++;
        end
        check_eq("chiprst_low_cycles", low_cnt, 16);
        check_eq("chiprst_no_strobes", bad, 0);
        check_eq("chiprst_busy_at_release", busy, 1'b1);
        tick();
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_rst_n", hpi_rst_n, 1'b1);
        check_eq("idle_state", dbg_state_o, 3'd1);

        // A write addr=2 data=0x1234
        run_access(1'b0, 1'b1, 2'd2, 16'h1234);
        check_eq("aw_grant_to_cs", m_first_cs, 1);
        check_eq("aw_setup", m_first_strobe - m_first_cs, 1);
        check_eq("aw_wr_low", m_wr_low, 4);
        check_eq("aw_rd_low", m_rd_low, 0);
        check_eq("aw_pins", m_pin_bad, 0);
        check_eq("aw_done_idx", m_done_idx, 6);
        check_eq("aw_cs_at_done", m_done_cs_n, 1'b0);
        check_eq("aw_other_done", m_other_done, 0);
        check_eq("aw_recover", m_recover, 2);
        check_eq("aw_idle_after", busy, 1'b0);

        // B read addr=0, chip returns 0xBEEF
        chip_q = 16'hBEEF;
        run_access(1'b1, 1'b0, 2'd0, 16'h0);
        check_eq("br_rd_low", m_rd_low, 4);
        check_eq("br_wr_low", m_wr_low, 0);
        check_eq("br_pins", m_pin_bad, 0);
        check_eq("br_done_idx", m_done_idx, 6);
        check_eq("br_rdata", m_rdata, 16'hBEEF);
        check_eq("br_other_done", m_other_done, 0);
        check_eq("br_a_rdata_kept", a_rdata, 16'h0);
        check_eq("br_b_rdata_hold", b_rdata, 16'hBEEF);

        // Both ports request continuously: A, B, A, B, A, B
        exp_q = {};
        for (int k = 0; k < 6; k++) exp_q.push_back((k % 2 == 0) ? 16'd0 : 16'd1);
        chip_q = 16'hC0DE;
        a_req = 1; a_we = 1; a_addr = 2'd3; a_wdata = 16'h5A00; a_lock = 0;
        b_req = 1; b_we = 0; b_addr = 2'd1; b_wdata = 16'h0;    b_lock = 0;
        n_done = 0; a_cnt = 0; b_cnt = 0; both = 0; c = 0; a_re = 0; b_re = 0;
        while (n_done < 6 && c < 300) begin
            tick();
            c++;
            if (a_re) begin a_req = 1'b1; a_wdata = a_wdata + 16'h1; a_re = 1'b0; end
            if (b_re) begin b_req = 1'b1; b_re = 1'b0; end
            if (a_done && b_done) both++;
            if (a_done || b_done) begin
                e = exp_q.pop_front();
                check_eq("rr_order", {15'd0, b_done}, e);
                n_done++;
                if (a_done) begin
                    a_cnt++;
                    a_req = 1'b0;
                    a_re  = (a_cnt < 3);
                end
                if (b_done) begin
                    b_cnt++;
                    check_eq("rr_b_rdata", b_rdata, chip_q);
                    chip_q = chip_q + 16'h1;
                    b_req = 1'b0;
                    b_re  = (b_cnt < 3);
                end
            end
        end
        check_eq("rr_done_count", n_done, 6);
        check_eq("rr_no_overlap", both, 0);
        a_req = 0; b_req = 0;
        repeat (6) tick();

        // Lock: A write lock=1 then A read lock=0, B contending throughout
        do_reset();
        exp_q = {};
`ifdef HPI_LOCK_EN
        exp_q.push_back(16'd0); exp_q.push_back(16'd0); exp_q.push_back(16'd1);
`else
        exp_q.push_back(16'd0); exp_q.push_back(16'd1); exp_q.push_back(16'd0);
`endif
        chip_q = 16'h7777;
        a_req = 1; a_we = 1; a_addr = 2'd1; a_wdata = 16'h00AA; a_lock = 1;
        b_req = 1; b_we = 0; b_addr = 2'd2; b_wdata = 16'h0;    b_lock = 0;
        n_done = 0; a_cnt = 0; c = 0; a_re = 0;
        while (n_done < 3 && c < 200) begin
            tick();
            c++;
            if (a_re) begin
                a_req = 1'b1; a_we = 1'b0; a_addr = 2'd2; a_lock = 1'b0; a_re = 1'b0;
            end
            if (a_done || b_done) begin
                e = exp_q.pop_front();
                check_eq("lock_order", {15'd0, b_done}, e);
                n_done++;
                if (a_done) begin
                    a_cnt++;
                    a_req = 1'b0;
                    a_re  = (a_cnt == 1);
                    if (a_cnt == 2) check_eq("lock_a_rdata", a_rdata, 16'h7777);
                end
                if (b_done) begin
                    check_eq("lock_b_rdata", b_rdata, 16'h7777);
                    b_req = 1'b0;
                end
            end
        end
        check_eq("lock_done_count", n_done, 3);
        a_req = 0; b_req = 0;
        repeat (6) tick();

        // Reset during STROBE of an A write
        a_req = 1; a_we = 1; a_addr = 2'd2; a_wdata = 16'hFACE; a_lock = 0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!hpi_wr_n) begin found = 1'b1; break; end
        end
        check_eq("mid_strobe_reached", found, 1'b1);
        tick();
        Reset = 1'b1;
        tick();
        a_req = 1'b0;
        check_eq("mid_wr_n", hpi_wr_n, 1'b1);
        check_eq("mid_cs_n", hpi_cs_n, 1'b1);
        check_eq("mid_data_oe", hpi_data_oe, 1'b0);
        check_eq("mid_state", dbg_state_o, 3'd0);
        check_eq("mid_rst_n", hpi_rst_n, 1'b0);
        check_eq("mid_no_done", a_done, 1'b0);
        Reset = 1'b0;
        n_done = 0;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (a_done || b_done) n_done++;
            if (!hpi_cs_n || !hpi_rd_n || !hpi_wr_n) bad++;
        end
        check_eq("mid_no_done_after", n_done, 0);
        check_eq("mid_no_strobes_after", bad, 0);
        check_eq("mid_back_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hpi_bus_arbiter.md
Name: hpi_bus_arbiter

Overview:
Arbitrates two requesters (port A: Nios-side bridge, port B: hardware keyboard poller) onto the single CY7C67200 HPI bus. Generates correctly timed active-low CS/RD/WR strobes, the 2-bit HPI address and the 16-bit data direction for each access. Holds the chip in reset for a programmable time after system reset. Sits between the Nios system's otg_hpi exports and the top-level OTG pins.

Parameters:
SETUP_CYC, 1, cycles address/CS are valid before the RD/WR strobe (min 1)
STROBE_CYC, 4, cycles RD_n/WR_n are held low (min 1)
HOLD_CYC, 1, cycles address/CS/data are held after strobe release (min 1)
RECOVER_CYC, 2, idle cycles with CS_n high between accesses (min 0)
RST_CYC, 16, cycles hpi_rst_n is held low after Reset

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
a_req  in  1  port A request; held high until a_done
a_we  in  1  port A: 1 = write, 0 = read
a_addr  in  2  port A HPI register address
a_wdata  in  16  port A write data
a_lock  in  1  port A keeps bus after this access
a_done  out  1  one-cycle pulse; access complete
a_rdata  out  16  port A read data, valid when a_done
b_req, b_we, b_addr, b_wdata, b_lock, b_done, b_rdata  same as port A for port B
hpi_addr  out  2  HPI address
hpi_cs_n  out  1  HPI chip select, active low
hpi_rd_n  out  1  HPI read strobe, active low
hpi_wr_n  out  1  HPI write strobe, active low
hpi_rst_n  out  1  HPI chip reset, active low
hpi_data_out  out  16  data driven to HPI
hpi_data_oe  out  1  1 = top level drives hpi_data_out onto the pad
hpi_data_in  in  16  data from the HPI pad
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - hpi_cs_n = hpi_rd_n = hpi_wr_n = 1; hpi_rst_n = 0.
  - hpi_addr = 0, hpi_data_out = 0, hpi_data_oe = 0.
  - a_done = b_done = 0; a_rdata = b_rdata = 0; busy = 1.
  - State = CHIPRST; round-robin pointer = A; lock owner = none.
- FSM states: CHIPRST, IDLE, SETUP, STROBE, HOLD, RECOVER. A single down-counter loads on each state entry.
- CHIPRST: hpi_rst_n = 0 for RST_CYC cycles, then hpi_rst_n = 1 and go to IDLE. No grants are issued.
- IDLE arbitration (evaluated each cycle):
  - If a lock owner is set, only the owner may be granted.
  - Otherwise, with one request pending, grant it.
  - Otherwise, with both pending, grant the side the round-robin pointer names; the pointer then flips to the other side.
- On grant (IDLE->SETUP):
  - Register we, addr, wdata and lock of the winner.
  - hpi_cs_n = 0 and hpi_addr = addr.
  - For writes, hpi_data_oe = 1 and hpi_data_out = wdata.
- Phase durations: SETUP lasts SETUP_CYC, STROBE lasts STROBE_CYC, HOLD lasts HOLD_CYC.
- STROBE: hpi_rd_n or hpi_wr_n = 0 per we. For reads, hpi_data_in is captured into the winner's rdata on the last STROBE cycle.
- HOLD:
  - Strobes high; CS_n, address and data_oe unchanged.
  - On the last HOLD cycle, pulse the winner's done for one cycle.
  - Lock owner = winner if its lock was 1, else none.
- RECOVER: hpi_cs_n = 1, hpi_data_oe = 0 for RECOVER_CYC cycles (skipped if 0), then IDLE.
- Minimum access latency, grant to done: SETUP_CYC + STROBE_CYC + HOLD_CYC cycles.
- The requester must drop req in the cycle after done. A req still high in IDLE is a new request.
- Locked owner not requesting in IDLE: the lock is held indefinitely. The owner releases it by issuing a final access with lock = 0.
- Reset asserted mid-access: all strobes and CS_n deassert in the next cycle, hpi_data_oe = 0, and the FSM returns to CHIPRST. No done pulse is issued.
- rdata holds its value until that port's next read completes.
- At most one strobe is low at any time; RD_n and WR_n are never both low.

Optional Feature:
HPI_LOCK_EN
- Defined: a_lock/b_lock are honoured as described above. This allows an atomic address-write + data-read pair, so the poller cannot interleave with the Nios.
- Undefined: lock inputs are ignored, the lock owner is always none, and arbitration is pure round-robin.

Test Plan:
- Reset, hold 3 cycles, release -> hpi_rst_n = 0 for 16 cycles then 1; busy falls one cycle later; no strobes during CHIPRST.
- A write addr=2, wdata=0x1234 -> timing and pin values:
  - CS_n low 1 cycle before WR_n; WR_n low exactly 4 cycles.
  - data_oe = 1 with data_out = 0x1234 throughout CS.
  - a_done pulses 6 cycles after grant; 2 cycles CS_n high before the next access.
- B read addr=0 with hpi_data_in = 0xBEEF during STROBE -> RD_n low 4 cycles, data_oe = 0, b_rdata = 0xBEEF when b_done pulses.
- A and B both request continuously (no lock) -> grants alternate B, A, B… after the first A; no port starves; done pulses alternate.
- HPI_LOCK_EN: A write with lock=1, B requesting -> next grant is A (read, lock=0); B is granted only afterwards. Without the macro, B is granted second.
- Reset asserted during STROBE of a write -> next cycle WR_n = CS_n = 1, data_oe = 0, no a_done, FSM restarts CHIPRST.
